scgra_alu_pipe: RTL and testbench
=================================

Name: scgra_alu_pipe

Overview:
- Parametrised successor to the SCGRA processing-element ALU.
- Every opcode has one uniform fixed latency, so results leave in issue order with a qualifying valid.
- Adds bitwise OR/XOR, variable shifts and a multiply-accumulate register with init/accumulate modes.
- Sits in each PE between the operand muxes (data memory/neighbour ports) and the PE result register.

Parameters:
- DWIDTH, 32, operand/result width (>=8).
- MUL_LAT, 4, internal multiplier pipeline depth in cycles (>=1).
- LAT, derived = MUL_LAT+3, issue-to-result latency (not overridable).

Ports:
- Clk  in  1  clock, all flops on rising edge.
- Resetn  in  1  asynchronous active-low reset.
- In_Valid  in  1  operands and opcode valid this cycle.
- OP_Sel  in  4  opcode.
- Data_In0  in  DWIDTH  operand A.
- Data_In1  in  DWIDTH  operand B.
- Data_In2  in  DWIDTH  operand C.
- Out_Valid  out  1  Data_Out carries a new result this cycle.
- Data_Out  out  DWIDTH  result.
- Acc_Out  out  DWIDTH  current accumulator value, registered.

Behaviour:
- Reset (async, Resetn=0): Out_Valid=0, Data_Out=0, Acc_Out=0, accumulator=0. All pipeline valid bits are cleared, so in-flight ops are discarded. No Out_Valid may follow from pre-reset issues.
- Pipeline: S0 input regs (A, B, C, op, valid) -> MUL_LAT multiply stages -> S_ADD post-add stage -> S_OUT output reg.
- Out_Valid rises exactly LAT cycles after the In_Valid cycle.
- Back-to-back issue is allowed every cycle. There is no stall and no backpressure.
- Non-multiply results are computed in the cycle after S0. They are carried through a MUL_LAT-deep delay line to stay aligned with products.
- Operand C is delayed to S_ADD alongside the product.
- Data_Out and Out_Valid update only for valid slots. When Out_Valid=0, Data_Out holds its last value.
- Opcodes (unsigned unless noted; results truncated to DWIDTH; product is the low DWIDTH bits of A*B):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 MUL: A*B
  - 3 MULADD: A*B+C
  - 4 AND: A&B
  - 5 OR: A|B
  - 6 XOR: A^B
  - 7 PHI: (A==0) ? C : B
  - 8 GT: (A>B) ? 1 : 0
  - 9 LET: (A<=B) ? 1 : 0
  - 10 SHL: A<<B[log2(DWIDTH)-1:0]
  - 11 SHR: logical A>>B[..]
  - 12 ASR: arithmetic A>>>B[..]
  - 13 MACC: acc <= acc + A*B; result = new acc
  - 14 MACI: acc <= A*B + C; result = new acc
  - 15 reserved: result 0, Out_Valid still asserted
- Shift amount: only the low ceil(log2(DWIDTH)) bits of B are used. An amount of 0 passes A unchanged.
- Accumulator is updated at S_ADD, only for valid MACC/MACI slots.
- Back-to-back MACC ops each see the previous op's updated value (forwarding inside S_ADD, no bubble).
- Acc_Out follows the accumulator one cycle after the update.
- Invalid slots (In_Valid=0) never modify the accumulator, regardless of OP_Sel.
- Accumulator wraps modulo 2^DWIDTH.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD, SUB, MULADD and MACC/MACI results are signed two's-complement saturating, clamped to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]. Overflow is detected on the DWIDTH+1-bit sum; products are the signed low-DWIDTH product.
- Undefined: all arithmetic wraps modulo 2^DWIDTH. Latency is identical either way.

Test Plan:
- Reset, then a single ADD with A=5, B=7 (MUL_LAT=4) -> Out_Valid high exactly 7 cycles later, Data_Out=12, high for 1 cycle.
- Issue ADD(1,2), MUL(3,4), MULADD(3,4,10), PHI(0,9,55) on 4 consecutive cycles -> outputs 3, 12, 22, 55 on 4 consecutive cycles, in order.
- MACI(2,3,1), then MACC(4,5), then MACC(1,1) back-to-back -> outputs 7, 27, 28; Acc_Out=28 one cycle after the last.
- Shifts, DWIDTH=32: SHL(1,33) -> 2; SHR(0x80000000,31) -> 1; ASR(0x80000000,4) -> 0xF8000000; GT(3,3) -> 0; LET(3,3) -> 1.
- Issue 3 MACC ops, assert Resetn=0 for 1 cycle while they are in flight -> no Out_Valid afterwards, Acc_Out=0, Data_Out=0.
- With ALU_SAT_EN: ADD(0x7FFFFFFF,1) -> 0x7FFFFFFF, SUB(0x80000000,1) -> 0x80000000. Without: 0x80000000 and 0x7FFFFFFF.

Source files
------------

// File: rtl/scgra_alu_pipe.sv
// scgra_alu_pipe: fixed-latency (LAT = MUL_LAT+3) SCGRA PE ALU with MAC accumulator; define ALU_SAT_EN for signed saturating ADD/SUB/MULADD/MACC/MACI
module scgra_alu_pipe #(
  parameter int DWIDTH  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              In_Valid,
  input  logic [3:0]        OP_Sel,
  input  logic [DWIDTH-1:0] Data_In0,
  input  logic [DWIDTH-1:0] Data_In1,
  input  logic [DWIDTH-1:0] Data_In2,
  output logic              Out_Valid,
  output logic [DWIDTH-1:0] Data_Out,
  output logic [DWIDTH-1:0] Acc_Out
);
  localparam int SW = $clog2(DWIDTH);
  localparam int L  = MUL_LAT - 1;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_MULADD = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_PHI = 4'd7;
  localparam logic [3:0] OP_GT = 4'd8, OP_LET = 4'd9, OP_SHL = 4'd10, OP_SHR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12, OP_MACC = 4'd13, OP_MACI = 4'd14;

  function automatic logic [DWIDTH-1:0] add_sat(input logic [DWIDTH-1:0] x, input logic [DWIDTH-1:0] y, input logic sub);
`ifdef ALU_SAT_EN
    logic [DWIDTH:0] s;
    s = sub ? {x[DWIDTH-1], x} - {y[DWIDTH-1], y} : {x[DWIDTH-1], x} + {y[DWIDTH-1], y};
    return (s[DWIDTH] != s[DWIDTH-1]) ? {s[DWIDTH], {(DWIDTH-1){~s[DWIDTH]}}} : s[DWIDTH-1:0];
`else
    return sub ? x - y : x + y;
`endif
  endfunction

  logic [DWIDTH-1:0] a0, b0, c0, r_nxt, mac_sum, add_nxt, add_r, acc;
  logic [3:0]        op0;
  logic              v0, add_v;
  logic [SW-1:0]     sh;
  logic [DWIDTH-1:0] p_q [MUL_LAT];
  logic [DWIDTH-1:0] r_q [MUL_LAT];
  logic [DWIDTH-1:0] c_q [MUL_LAT];
  logic [3:0]        op_q [MUL_LAT];
  logic              v_q [MUL_LAT];

  // S0: register operands, opcode and slot valid
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      v0  <= 1'b0;
      op0 <= '0;
      a0  <= '0;
      b0  <= '0;
      c0  <= '0;
    end else begin
      v0  <= In_Valid;
      op0 <= OP_Sel;
      a0  <= Data_In0;
      b0  <= Data_In1;
      c0  <= Data_In2;
    end
  end

  // Non-multiply result, computed from S0 so it can ride the product delay line
  always_comb begin
    r_nxt = '0;
    sh    = b0[SW-1:0];
    case (op0)
      OP_ADD:  r_nxt = add_sat(a0, b0, 1'b0);
      OP_SUB:  r_nxt = add_sat(a0, b0, 1'b1);
      OP_AND:  r_nxt = a0 & b0;
      OP_OR:   r_nxt = a0 | b0;
      OP_XOR:  r_nxt = a0 ^ b0;
      OP_PHI:  r_nxt = (a0 == '0) ? c0 : b0;
      OP_GT:   r_nxt = {{(DWIDTH-1){1'b0}}, a0 > b0};
      OP_LET:  r_nxt = {{(DWIDTH-1){1'b0}}, a0 <= b0};
      OP_SHL:  r_nxt = a0 << sh;
      OP_SHR:  r_nxt = a0 >> sh;
      OP_ASR:  r_nxt = $signed(a0) >>> sh;
      default: r_nxt = '0;
    endcase
  end

  // Multiplier pipeline with C, opcode, valid and the non-multiply result delayed alongside
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        p_q[i]  <= '0;
        r_q[i]  <= '0;
        c_q[i]  <= '0;
        op_q[i] <= '0;
        v_q[i]  <= 1'b0;
      end
    end else begin
      p_q[0]  <= a0 * b0;
      r_q[0]  <= r_nxt;
      c_q[0]  <= c0;
      op_q[0] <= op0;
      v_q[0]  <= v0;
      for (int i = 1; i < MUL_LAT; i++) begin
        p_q[i]  <= p_q[i-1];
        r_q[i]  <= r_q[i-1];
        c_q[i]  <= c_q[i-1];
        op_q[i] <= op_q[i-1];
        v_q[i]  <= v_q[i-1];
      end
    end
  end

  // Post-add: product plus C or the live accumulator, then final result select
  always_comb begin
    mac_sum = add_sat(p_q[L], op_q[L] == OP_MACC ? acc : c_q[L], 1'b0);
    add_nxt = op_q[L] == OP_MUL ? p_q[L] :
              (op_q[L] == OP_MULADD || op_q[L] == OP_MACC || op_q[L] == OP_MACI) ? mac_sum : r_q[L];
  end

  // S_ADD register and accumulator; back-to-back MACs read the freshly written acc
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      add_v <= 1'b0;
      add_r <= '0;
      acc   <= '0;
    end else begin
      add_v <= v_q[L];
      add_r <= add_nxt;
      if (v_q[L] && (op_q[L] == OP_MACC || op_q[L] == OP_MACI)) acc <= mac_sum;
    end
  end

  // S_OUT: Data_Out holds across invalid slots, Acc_Out trails the accumulator by one cycle
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Out_Valid <= 1'b0;
      Data_Out  <= '0;
      Acc_Out   <= '0;
    end else begin
      Out_Valid <= add_v;
      Acc_Out   <= acc;
      if (add_v) Data_Out <= add_r;
    end
  end
endmodule

// File: tb/tb_scgra_alu_pipe.sv
// tb_scgra_alu_pipe: directed and random checks of scgra_alu_pipe against an issue-order arithmetic model
module tb_scgra_alu_pipe;
  localparam int LAT = 7;

  logic        Clk = 1'b0, Resetn = 1'b1, In_Valid = 1'b0;
  logic [3:0]  OP_Sel = '0;
  logic [31:0] Data_In0 = '0, Data_In1 = '0, Data_In2 = '0;
  logic        Out_Valid;
  logic [31:0] Data_Out, Acc_Out;

  int total = 0, bad = 0, cyc = 0;
  logic [31:0] m_acc = '0, last_d = '0, exp_acc = '0;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        mac;
    logic [31:0] acc;
  } ent_t;
  ent_t sb[$];

  scgra_alu_pipe #(.DWIDTH(32), .MUL_LAT(4)) dut (
    .Clk(Clk), .Resetn(Resetn), .In_Valid(In_Valid), .OP_Sel(OP_Sel),
    .Data_In0(Data_In0), .Data_In1(Data_In1), .Data_In2(Data_In2),
    .Out_Valid(Out_Valid), .Data_Out(Data_Out), .Acc_Out(Acc_Out)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic longint sx(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic logic [31:0] fix(input longint s);
`ifdef ALU_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check();
    logic ev;
    ent_t e;
    ev = sb.size() > 0 && sb[0].due == cyc;
    chk("out_valid", 32'(Out_Valid), 32'(ev));
    if (ev) begin
      e = sb.pop_front();
      last_d = e.d;
      if (e.mac) exp_acc = e.acc;
    end
    chk("data_out", Data_Out, last_d);
    chk("acc_out", Acc_Out, exp_acc);
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ent_t e;
    logic [63:0] f;
    logic [31:0] p, r;
    logic signed [31:0] sa;
    logic [4:0] sh;
    @(posedge Clk);
    #1;
    Resetn = 1'b1;
    In_Valid = v;
    OP_Sel = op;
    Data_In0 = a;
    Data_In1 = b;
    Data_In2 = c;
    if (v) begin
      f = {32'b0, a} * {32'b0, b};
      p = f[31:0];
      sa = a;
      sh = b[4:0];
      case (op)
        0: r = fix(sx(a) + sx(b));
        1: r = fix(sx(a) - sx(b));
        2: r = p;
        3: r = fix(sx(p) + sx(c));
        4: r = a & b;
        5: r = a | b;
        6: r = a ^ b;
        7: r = (a == 0) ? c : b;
        8: r = (a > b) ? 32'd1 : 32'd0;
        9: r = (a <= b) ? 32'd1 : 32'd0;
        10: r = a << sh;
        11: r = a >> sh;
        12: r = sa >>> sh;
        13: begin m_acc = fix(sx(m_acc) + sx(p)); r = m_acc; end
        14: begin m_acc = fix(sx(p) + sx(c)); r = m_acc; end
        default: r = 32'd0;
      endcase
      e.due = cyc + LAT;
      e.d = r;
      e.mac = (op == 13 || op == 14);
      e.acc = m_acc;
      sb.push_back(e);
    end
    @(negedge Clk);
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge Clk);
    #1;
    Resetn = 1'b0;
    In_Valid = 1'b0;
    sb.delete();
    m_acc = '0;
    exp_acc = '0;
    last_d = '0;
    @(negedge Clk);
    check();
  endtask

  initial begin
    #2 Resetn = 1'b0;
    @(negedge Clk);
    check();
    pulse_reset();

    step(1, 0, 5, 7, 0);
    idle(LAT);
    chk("add_valid", 32'(Out_Valid), 32'd1);
    chk("add_data", Data_Out, 32'd12);
    idle(1);
    chk("add_pulse", 32'(Out_Valid), 32'd0);

    step(1, 0, 1, 2, 0);
    step(1, 2, 3, 4, 0);
    step(1, 3, 3, 4, 10);
    step(1, 7, 0, 9, 55);
    idle(LAT);
    chk("phi_data", Data_Out, 32'd55);
    idle(1);

    step(1, 14, 2, 3, 1);
    step(1, 13, 4, 5, 0);
    step(1, 13, 1, 1, 0);
    idle(LAT);
    chk("macc_data", Data_Out, 32'd28);
    idle(1);
    chk("macc_acc", Acc_Out, 32'd28);

    step(1, 10, 1, 33, 0);
    step(1, 11, 32'h80000000, 31, 0);
    step(1, 12, 32'h80000000, 4, 0);
    step(1, 8, 3, 3, 0);
    step(1, 9, 3, 3, 0);
    step(1, 10, 32'hABCD, 0, 0);
    step(1, 12, 32'h80000001, 32, 0);
    step(1, 15, 5, 5, 5);
    step(0, 13, 9, 9, 9);
    step(0, 14, 9, 9, 9);
    step(1, 13, 1, 1, 0);
    idle(LAT + 1);

    step(1, 0, 32'h7FFFFFFF, 1, 0);
    step(1, 1, 32'h80000000, 1, 0);
    step(1, 3, 32'h10000, 32'h8000, 32'h7FFFFFFF);
    step(1, 14, 32'h7FFFFFFF, 1, 1);
    step(1, 13, 32'h7FFFFFFF, 1, 0);
    step(1, 13, 32'hFFFFFFFF, 32'h80000000, 0);
    idle(LAT + 1);

    step(1, 13, 3, 3, 0);
    step(1, 13, 4, 4, 0);
    step(1, 13, 5, 5, 0);
    pulse_reset();
    idle(LAT + 2);
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_acc", Acc_Out, 32'd0);
    chk("rst_data", Data_Out, 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      step($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), rnd_operand());
    end
    idle(LAT + 2);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
